// File: rtl/rgb_hue_sequencer_if.sv
// rtl/rgb_hue_sequencer_if.sv - level/phase bundle from the hue sequencer to the RGB PWM stage
interface rgb_hue_sequencer_if;
    logic [7:0] red_level;
    logic [7:0] green_level;
    logic [7:0] blue_level;
    logic [2:0] phase;
    logic       level_valid;

    modport master (
        output red_level,
        output green_level,
        output blue_level,
        output phase,
        output level_valid
    );

    modport slave (
        input red_level,
        input green_level,
        input blue_level,
        input phase,
        input level_valid
    );
endinterface

// File: rtl/rgb_hue_sequencer.sv
// rtl/rgb_hue_sequencer.sv - prescaled 6-phase hue wheel producing 8-bit RGB levels
module rgb_hue_sequencer #(
    parameter int DIV    = 16,
    parameter int STEP   = 1,
    parameter bit INVERT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    rgb_hue_sequencer_if.master   led
);

    localparam logic [8:0] STEP9   = 9'(STEP);
    localparam logic [7:0] RST_RED = INVERT ? 8'h00 : 8'hFF;
    localparam logic [7:0] RST_GB  = INVERT ? 8'hFF : 8'h00;

    logic [DIV-1:0] presc_q, presc_d;
    logic [7:0]     ramp_q, ramp_d;
    logic [2:0]     phase_r_q, phase_r_d;
    logic           upd_q, upd_d;
    logic [7:0]     red_q, red_d;
    logic [7:0]     green_q, green_d;
    logic [7:0]     blue_q, blue_d;
    logic [2:0]     phase_q, phase_d;
    logic           valid_q, valid_d;

    logic           tick;
    logic [8:0]     ramp_sum;
    logic [7:0]     r_map, g_map, b_map;

    assign tick     = enable && (presc_q == {DIV{1'b1}});
    assign ramp_sum = {1'b0, ramp_q} + STEP9;

    always_comb begin
        presc_d   = presc_q;
        ramp_d    = ramp_q;
        phase_r_d = phase_r_q;
        if (enable) begin
            presc_d = presc_q + DIV'(1);
        end
        if (tick) begin
            // Out-of-range phases snap back to the start of the wheel.
            if (phase_r_q > 3'd5) begin
                ramp_d    = 8'd0;
                phase_r_d = 3'd0;
            end else if (ramp_q == 8'hFF) begin
                ramp_d    = 8'd0;
                phase_r_d = (phase_r_q == 3'd5) ? 3'd0 : phase_r_q + 3'd1;
            end else begin
                ramp_d = ramp_sum[8] ? 8'hFF : ramp_sum[7:0];
            end
        end
    end

    always_comb begin
        r_map = 8'hFF;
        g_map = 8'h00;
        b_map = 8'h00;
        case (phase_r_q)
            3'd0: begin r_map = 8'hFF;    g_map = ramp_q;  b_map = 8'h00;   end
            3'd1: begin r_map = ~ramp_q;  g_map = 8'hFF;   b_map = 8'h00;   end
            3'd2: begin r_map = 8'h00;    g_map = 8'hFF;   b_map = ramp_q;  end
            3'd3: begin r_map = 8'h00;    g_map = ~ramp_q; b_map = 8'hFF;   end
            3'd4: begin r_map = ramp_q;   g_map = 8'h00;   b_map = 8'hFF;   end
            3'd5: begin r_map = 8'hFF;    g_map = 8'h00;   b_map = ~ramp_q; end
            default: begin r_map = 8'hFF; g_map = 8'h00;   b_map = 8'h00;   end
        endcase
    end

    // Output stage loads one cycle after a tick and is deliberately not gated by enable.
    always_comb begin
        upd_d   = tick;
        valid_d = upd_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        phase_d = phase_q;
        if (upd_q) begin
            red_d   = INVERT ? ~r_map : r_map;
            green_d = INVERT ? ~g_map : g_map;
            blue_d  = INVERT ? ~b_map : b_map;
            phase_d = phase_r_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            ramp_q    <= 8'd0;
            phase_r_q <= 3'd0;
            upd_q     <= 1'b0;
            red_q     <= RST_RED;
            green_q   <= RST_GB;
            blue_q    <= RST_GB;
            phase_q   <= 3'd0;
            valid_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            ramp_q    <= ramp_d;
            phase_r_q <= phase_r_d;
            upd_q     <= upd_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            phase_q   <= phase_d;
            valid_q   <= valid_d;
        end
    end

    assign led.red_level   = red_q;
    assign led.green_level = green_q;
    assign led.blue_level  = blue_q;
    assign led.phase       = phase_q;
    assign led.level_valid = valid_q;

endmodule
